sdram_write_master: RTL

- Avalon-MM burst write master. Drains execution-unit result beats from a valid/ready stream into SDRAM.
- Write-side counterpart of the SDRAM read fetch path.
- Sits between the EU groups (result producers) and the SDRAM controller write port; driven by a start/address/length command from the control unit.
- Buffers incoming beats in a small FIFO and issues a burst only when the whole burst is already buffered.

---
 rtl/sdram_write_master_pkg.sv | 25 ++
 rtl/sdram_write_master_if.sv | 28 ++
 rtl/sdram_write_master_sync_fifo.sv | 54 +++++
 rtl/sdram_write_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sdram_write_master_pkg.sv
// Shared types and size helpers for the SDRAM burst write master.
// BYTES_PER_BEAT / BURSTCOUNT_W describe the default build; the functions serve other parameterisations.
package sdram_pkg;

    localparam int DEF_SDRAM_W    = 128;
    localparam int DEF_MAX_BURST  = 8;
    localparam int BYTES_PER_BEAT = DEF_SDRAM_W / 8;
    localparam int BURSTCOUNT_W   = $clog2(DEF_MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } wm_state_e;

    function automatic int bytes_per_beat(input int sdram_w);
        return sdram_w / 8;
    endfunction

    function automatic int burstcount_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/sdram_write_master_if.sv
// Avalon-MM burst write port between the write master and the SDRAM controller.
interface sdram_write_master_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int SDRAM_W   = 128,
    parameter int MAX_BURST = 8
);
    localparam int BC_W = burstcount_w(MAX_BURST);

    logic [ADDR_W-1:0]    avm_address;
    logic                 avm_write;
    logic [SDRAM_W-1:0]   avm_writedata;
    logic [SDRAM_W/8-1:0] avm_byteenable;
    logic [BC_W-1:0]      avm_burstcount;
    logic                 avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        output avm_waitrequest
    );

endinterface

// File: rtl/sdram_write_master_sync_fifo.sv
// Single-clock FIFO with occupancy count; the caller never pushes while full or pops while empty.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sdram_write_master.sv
// Avalon-MM burst write master: buffers stream beats and issues a burst only once it is fully buffered.
// Optional macro SDRAM_WR_STALL_CNT_EN adds the stall_cnt output (cycles spent in waitrequest).
module sdram_write_master
    import sdram_pkg::*;
#(
    parameter int SDRAM_W    = 128,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 cmd_ready,
    output logic                 busy,
    output logic                 done,
    input  logic [SDRAM_W-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    sdram_write_master_if.master avm
`ifdef SDRAM_WR_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int BEAT_SHIFT = $clog2(bytes_per_beat(SDRAM_W));
    localparam int BC_W       = burstcount_w(MAX_BURST);
    localparam int FC_W       = $clog2(FIFO_DEPTH) + 1;

    wm_state_e          state_q;
    logic [LEN_W-1:0]   beats_left_q, wr_left_q;
    logic [BC_W-1:0]    burst_left_q, burstcount_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q, done_q;

    logic               fifo_full, fifo_empty;
    logic [FC_W-1:0]    fifo_count;
    logic [SDRAM_W-1:0] fifo_head;
    logic               push, pop, beat_done;
    logic [BC_W-1:0]    blen;

    assign in_ready  = (state_q != IDLE) && !fifo_full && (beats_left_q != '0);
    assign push      = in_valid && in_ready;
    assign beat_done = write_q && !avm.avm_waitrequest;
    assign pop       = beat_done && !fifo_empty;
    assign blen      = (wr_left_q >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(wr_left_q);

    sync_fifo #(
        .WIDTH (SDRAM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (in_data),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            wr_left_q    <= '0;
            burst_left_q <= '0;
            burstcount_q <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) beats_left_q <= beats_left_q - LEN_W'(1);
            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        addr_q       <= cmd_addr;
                        beats_left_q <= cmd_len;
                        wr_left_q    <= cmd_len;
                        if (cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (fifo_count >= FC_W'(blen)) begin
                        write_q      <= 1'b1;
                        burstcount_q <= blen;
                        burst_left_q <= blen;
                        state_q      <= BURST;
                    end
                end
                BURST: begin
                    if (beat_done) begin
                        wr_left_q    <= wr_left_q - LEN_W'(1);
                        burst_left_q <= burst_left_q - BC_W'(1);
                        if (burst_left_q == BC_W'(1)) begin
                            write_q <= 1'b0;
                            addr_q  <= addr_q + (ADDR_W'(burstcount_q) << BEAT_SHIFT);
                            if (wr_left_q == LEN_W'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_WR_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && cmd_start) begin
            stall_cnt_q <= '0;
        end else if (write_q && avm.avm_waitrequest && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // Writedata is forced to zero between bursts so reset and idle look clean on the bus.
    assign avm.avm_address    = addr_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = write_q ? fifo_head : '0;
    assign avm.avm_byteenable = '1;
    assign avm.avm_burstcount = burstcount_q;
    assign cmd_ready          = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign done               = done_q;

endmodule
